// File: rtl/stencil_stream_sink_pkg.sv
// Shared types for the stencil stream sink: FSM state encoding and per-pixel tags.
package stream_pkg;

  localparam int TAG_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    WARM,
    STREAM,
    DRAIN
  } state_t;

  typedef struct packed {
    logic sol;
    logic eol;
    logic eof;
  } tag_t;

endpackage

// File: rtl/stencil_stream_sink_if.sv
// Downstream valid/ready pixel stream carrying line and frame markers.
interface stencil_stream_sink_if #(
  parameter int DATA_W = 16
);

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_sol;
  logic              out_eol;
  logic              out_eof;

  modport master (
    output out_data, out_valid, out_sol, out_eol, out_eof,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_sol, out_eol, out_eof,
    output out_ready
  );

endinterface

// File: rtl/stencil_stream_sink_fifo.sv
// Small synchronous FIFO; the extra pointer bit distinguishes full from empty.
module sync_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Head is forced to zero when empty so stale memory never reaches the outputs.
  assign dout = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/stencil_stream_sink.sv
// Frame sink: drops pipeline warm-up samples, tags pixels with SOL/EOL/EOF, buffers them for a
// valid/ready consumer and flags samples lost to backpressure.
module stencil_stream_sink
  import stream_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int IMG_W      = 64,
  parameter int IMG_H      = 64,
  parameter int WARMUP     = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  stencil_stream_sink_if.master out_if,
  output logic                  busy,
  output logic                  overflow,
  output logic                  frame_done
);

  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int WW   = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int FCW  = $clog2(FIFO_DEPTH) + 1;
  localparam int FW   = DATA_W + TAG_W;

  state_t          state_reg, state_next;
  logic [WW-1:0]   warm_cnt_reg;
  logic [CW-1:0]   col_reg;
  logic [RW-1:0]   row_reg;
  logic            overflow_reg;
  logic            frame_done_reg;

  logic            frame_start, warm_step, stream_step;
  logic            warm_last, col_last, row_last;
  logic            push, pop, drop, drain_empty;
  tag_t            in_tag, head_tag;
  logic [FW-1:0]   fifo_dout;
  logic            fifo_full, fifo_empty;
  logic [FCW-1:0]  fifo_count;

  assign warm_last = (warm_cnt_reg == WW'(WARMUP - 1));
  assign col_last  = (col_reg == CW'(IMG_W - 1));
  assign row_last  = (row_reg == RW'(IMG_H - 1));

  assign in_tag.sol = (col_reg == '0);
  assign in_tag.eol = col_last;
  assign in_tag.eof = col_last && row_last;

  assign pop  = out_if.out_valid && out_if.out_ready;
  assign push = stream_step && (!fifo_full || pop);
  assign drop = stream_step && !push;
  // Only pops happen while draining, so the FIFO goes empty on the pop of its last entry.
  assign drain_empty = fifo_empty || (pop && fifo_count == FCW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      frame_done_reg <= (state_reg == DRAIN) && (state_next == IDLE);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (WARMUP == 0) ? STREAM : WARM;
      WARM:    if (in_valid && warm_last) state_next = STREAM;
      STREAM:  if (in_valid && col_last && row_last) state_next = DRAIN;
      DRAIN:   if (drain_empty) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_reg != IDLE);
    frame_start = 1'b0;
    warm_step   = 1'b0;
    stream_step = 1'b0;
    case (state_reg)
      IDLE:    frame_start = start;
      WARM:    warm_step   = in_valid;
      STREAM:  stream_step = in_valid;
      default: ;
    endcase
  end

  // Dropped samples still advance the position so tags stay locked to image geometry.
  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      warm_cnt_reg <= '0;
      col_reg      <= '0;
      row_reg      <= '0;
    end else begin
      if (warm_step) begin
        warm_cnt_reg <= warm_last ? '0 : warm_cnt_reg + 1'b1;
      end
      if (stream_step) begin
        if (col_last) begin
          col_reg <= '0;
          row_reg <= row_last ? '0 : row_reg + 1'b1;
        end else begin
          col_reg <= col_reg + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      overflow_reg <= 1'b0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({in_tag, in_data}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head_tag         = tag_t'(fifo_dout[DATA_W +: TAG_W]);
  assign out_if.out_data  = fifo_dout[DATA_W-1:0];
  assign out_if.out_valid = !fifo_empty;
  assign out_if.out_sol   = head_tag.sol;
  assign out_if.out_eol   = head_tag.eol;
  assign out_if.out_eof   = head_tag.eof;

  assign overflow   = overflow_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_stencil_stream_sink.sv
// Bench for stencil_stream_sink: vector table, directed corner cases and random traffic
// checked every cycle against a queue-based frame model.
module tb_stencil_stream_sink;

  localparam int DATA_W = 16;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 2;
  localparam int WARMUP = 3;
  localparam int DEPTH  = 4;
  localparam int NPIX   = IMG_W * IMG_H;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              busy;
  logic              overflow;
  logic              frame_done;

  stencil_stream_sink_if #(.DATA_W(DATA_W)) sif ();

  stencil_stream_sink #(
    .DATA_W     (DATA_W),
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H),
    .WARMUP     (WARMUP),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .out_if     (sif),
    .busy       (busy),
    .overflow   (overflow),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pixels as {sol,eol,eof,data}; frame position from a plain sample index.
  logic [DATA_W+2:0] mq[$];
  logic [DATA_W+2:0] got[$];
  bit m_active, m_drain, m_ovf, m_done;
  int m_idx;
  bit log_pops = 1'b1;

  typedef struct {
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              ready;
    logic              exp_valid;
    logic [DATA_W+2:0] exp_head;
    logic              exp_busy;
    logic              exp_done;
  } vec_t;

  vec_t              tbl[14];
  logic [2:0]        ntag[8];
  logic [DATA_W+2:0] exp_pix[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [DATA_W+2:0] e;
    int p;
    bit pop;
    if (rst) begin
      mq.delete();
      m_active = 0; m_drain = 0; m_idx = 0; m_ovf = 0; m_done = 0;
      return;
    end
    m_done = 0;
    pop = (mq.size() > 0) && sif.out_ready;
    if (pop) e = mq.pop_front();
    if (!m_active) begin
      if (start) begin
        m_active = 1; m_idx = 0; m_ovf = 0;
      end
    end else if (!m_drain) begin
      if (in_valid) begin
        if (m_idx >= WARMUP) begin
          p = m_idx - WARMUP;
          e = {(p % IMG_W) == 0, (p % IMG_W) == IMG_W - 1, p == NPIX - 1, in_data};
          if (mq.size() < DEPTH) mq.push_back(e);
          else m_ovf = 1;
        end
        m_idx++;
        if (m_idx == WARMUP + NPIX) m_drain = 1;
      end
    end else if (mq.size() == 0) begin
      m_active = 0; m_drain = 0; m_done = 1;
    end
  endtask

  task automatic compare_model();
    logic [DATA_W+2:0] exp_head;
    exp_head = (mq.size() > 0) ? mq[0] : '0;
    check("m_valid", sif.out_valid, mq.size() > 0);
    check("m_head", {sif.out_sol, sif.out_eol, sif.out_eof, sif.out_data}, exp_head);
    check("m_busy", busy, m_active);
    check("m_overflow", overflow, m_ovf);
    check("m_frame_done", frame_done, m_done);
  endtask

  task automatic tick();
    if (sif.out_valid && sif.out_ready) begin
      got.push_back({sif.out_sol, sif.out_eol, sif.out_eof, sif.out_data});
      if (log_pops)
        $display("pop data=%0d sol=%0b eol=%0b eof=%0b", sif.out_data, sif.out_sol,
                 sif.out_eol, sif.out_eof);
    end
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  task automatic run_until_idle(input int max_cycles);
    int n = 0;
    while (busy && n < max_cycles) begin
      tick();
      n++;
    end
    check("drain_timeout", busy, 1'b0);
  endtask

  task automatic send(input logic [DATA_W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_got(input string name, input int n);
    check({name, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) check(name, got[i], exp_pix[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; sif.out_ready = 1'b0;

    ntag = '{3'b100, 3'b000, 3'b000, 3'b010, 3'b100, 3'b000, 3'b000, 3'b011};
    for (int i = 0; i < 8; i++) exp_pix[i] = {ntag[i], 16'(3 + i)};
    tbl[0] = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b0, '0, 1'b1, 1'b0};
    for (int k = 0; k < 11; k++) begin
      if (k < 3) tbl[k+1] = '{1'b0, 1'b1, 16'(k), 1'b1, 1'b0, '0, 1'b1, 1'b0};
      else       tbl[k+1] = '{1'b0, 1'b1, 16'(k), 1'b1, 1'b1, exp_pix[k-3], 1'b1, 1'b0};
    end
    tbl[12] = '{1'b0, 1'b0, 16'd0, 1'b1, 1'b0, '0, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 16'd0, 1'b1, 1'b0, '0, 1'b0, 1'b0};

    // Reset and idle behaviour
    tick();
    tick();
    rst = 1'b0;
    check("rst_outputs", {sif.out_valid, sif.out_sol, sif.out_eol, sif.out_eof, busy,
                          overflow, frame_done}, 7'b0);
    check("rst_data", sif.out_data, 16'd0);
    send(16'hABCD);
    tick();
    check("idle_in_valid", sif.out_valid, 1'b0);

    // Nominal frame from the vector table
    for (int i = 0; i < 14; i++) begin
      start         = tbl[i].start;
      in_valid      = tbl[i].in_valid;
      in_data       = tbl[i].in_data;
      sif.out_ready = tbl[i].ready;
      tick();
      check("tbl_valid", sif.out_valid, tbl[i].exp_valid);
      check("tbl_head", {sif.out_sol, sif.out_eol, sif.out_eof, sif.out_data}, tbl[i].exp_head);
      check("tbl_busy", busy, tbl[i].exp_busy);
      check("tbl_done", frame_done, tbl[i].exp_done);
      check("tbl_overflow", overflow, 1'b0);
    end
    start = 1'b0; in_valid = 1'b0;

    // Sparse input: one valid sample every third cycle
    got.delete();
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 11; k++) begin
      send(16'(k));
      tick();
      tick();
    end
    run_until_idle(50);
    check_got("sparse", 8);
    check("sparse_overflow", overflow, 1'b0);

    // Backpressure: only four pixels fit, the rest are dropped
    got.delete();
    sif.out_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 11; k++) send(16'(k));
    check("bp_overflow", overflow, 1'b1);
    check("bp_occupancy", dut.u_fifo.count, 4);
    sif.out_ready = 1'b1;
    run_until_idle(50);
    check_got("bp", 4);
    check("bp_overflow_hold", overflow, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    check("bp_restart_clear", overflow, 1'b0);
    do_reset();

    // Full FIFO with simultaneous pop accepts the push
    sif.out_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 7; k++) send(16'(k));
    check("full_occupancy", dut.u_fifo.count, 4);
    sif.out_ready = 1'b1;
    send(16'd7);
    check("full_pop_overflow", overflow, 1'b0);
    check("full_pop_occupancy", dut.u_fifo.count, 4);
    for (int k = 8; k < 11; k++) send(16'(k));
    run_until_idle(50);
    check("full_pop_overflow_end", overflow, 1'b0);

    // Reset in the middle of a frame
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 8; k++) send(16'(k));
    sif.out_ready = 1'b0;
    do_reset();
    check("midrst_valid", sif.out_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", frame_done, 1'b0);
    tick();
    check("midrst_done_after", frame_done, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 4; k++) send(16'(100 + k));
    check("midrst_first_valid", sif.out_valid, 1'b1);
    check("midrst_first_sol", sif.out_sol, 1'b1);
    check("midrst_first_data", sif.out_data, 16'd103);
    do_reset();

    // Random traffic against the model
    log_pops = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      start         = ($urandom_range(0, 7) == 0);
      in_valid      = ($urandom_range(0, 3) != 0);
      in_data       = 16'($urandom);
      sif.out_ready = ($urandom_range(0, 2) != 0);
      rst           = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; sif.out_ready = 1'b1;
    tick();
    run_until_idle(50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stencil_stream_sink.md
# stencil_stream_sink

Consumer end of a stencil pipeline. It takes the free-running output pixel stream of the last kernel stage, discards the pipeline-fill (warm-up) samples, and tags each pixel with start-of-line, end-of-line and end-of-frame markers. Tagged pixels are buffered in a small FIFO and handed to a downstream valid/ready interface such as a DMA or memory writer. The upstream kernel/line-buffer chain cannot be stalled, so backpressure beyond FIFO capacity drops samples and is reported.

## Interface
- DATA_W, 16, pixel width
- IMG_W, 64, pixels per line (≥2)
- IMG_H, 64, lines per frame (≥1)
- WARMUP, 5, valid input samples discarded at frame start (pipeline fill latency)
- FIFO_DEPTH, 4, FIFO entries (power of two, ≥2)
- Reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, sampled on rising edge of clk
- start  in  1  begin a frame; honoured only in IDLE
- in_data  in  DATA_W  pixel from the final kernel stage
- in_valid  in  1  in_data is a real sample this cycle
- out_data  out  DATA_W  FIFO head pixel
- out_valid  out  1  FIFO not empty
- out_ready  in  1  downstream accepts the head this cycle
- out_sol  out  1  head pixel is column 0
- out_eol  out  1  head pixel is column IMG_W-1
- out_eof  out  1  head pixel is the last pixel of the frame
- busy  out  1  state ≠ IDLE
- overflow  out  1  sticky: at least one sample dropped this frame
- frame_done  out  1  one-cycle pulse when the frame is fully drained

## Operation
- FSM states are IDLE, WARM, STREAM and DRAIN.
  - IDLE → WARM on start. If WARMUP = 0, IDLE goes directly to STREAM.
  - WARM: count valid samples. Each is discarded. → STREAM after the WARMUP-th valid sample.
  - STREAM: each valid sample is pushed with tags {sol, eol, eof}.
    - col counts 0..IMG_W-1. row counts 0..IMG_H-1.
    - After the sample with row = IMG_H-1 and col = IMG_W-1 is handled (pushed or dropped) → DRAIN.
  - DRAIN: input is ignored. When the FIFO is empty → IDLE and assert frame_done for one cycle.
- Counters advance only on in_valid. Gaps in in_valid are legal in every state.
- Push rule: a push succeeds if the FIFO is not full, or if it is full and a pop happens in the same cycle.
  - Otherwise the sample is dropped and overflow sets.
  - A dropped sample still advances col and row, so the tags stay aligned with image geometry.
- overflow clears on rst and on an accepted start. It holds through IDLE.
- Pop happens when out_valid && out_ready. out_data and the tags show the FIFO head with no combinational path from the inputs.
- start while busy is ignored.
- in_valid in IDLE or DRAIN is ignored.
- rst mid-frame: the FIFO empties, counters zero, state goes to IDLE. No frame_done.
- Reset values: out_valid, out_sol, out_eol, out_eof, busy, overflow and frame_done are 0. out_data is 0.

## Timing
- A sample accepted in cycle N is visible on out_data/out_valid in cycle N+1 when the FIFO was empty. There is no bypass.
- The STREAM transition is registered. The first sample after the WARMUP-th valid sample is the first one pushed.
- frame_done asserts in the cycle after the pop that empties the FIFO in DRAIN. busy drops in that same cycle.
- Worst-case throughput is 1 pixel/cycle in and 1 pixel/cycle out.

## Structure
- Package stream_pkg holds:
  - the state enum (IDLE, WARM, STREAM, DRAIN);
  - the tag struct {sol, eol, eof};
  - the constant TAG_W = 3.
- Sub-module sync_fifo is parameterised by width (DATA_W+TAG_W) and depth.
  - It registers memory and pointers and uses an extra pointer bit for full/empty.
  - It provides full, empty, push and pop, and is synchronous-reset.
- The top level contains the FSM, the warm-up counter, the col/row counters, tag generation and overflow.

## Test plan
All scenarios use IMG_W=4, IMG_H=2, WARMUP=3, FIFO_DEPTH=4.
- Reset: assert rst for 2 cycles → all outputs 0 and busy 0. An in_valid pulse while in IDLE produces no out_valid.
- Nominal frame: start, then in_data 0..10 with continuous valid and out_ready=1.
  - 0, 1 and 2 are dropped. Output is 3..10.
  - sol on 3 and 7; eol on 6 and 10; eof on 10.
  - frame_done fires 1 cycle after 10 is popped. overflow stays 0.
- Sparse input: same frame with in_valid every third cycle → identical output sequence and tags.
- Backpressure: out_ready=0 during STREAM.
  - 3, 4, 5 and 6 are buffered. 7..10 are dropped and overflow = 1.
  - With out_ready=1, output is 3..6 with eol on 6. FSM reaches IDLE and frame_done fires. A next start clears overflow.
- Full with simultaneous pop: FIFO holds 4 entries, then in_valid and out_ready are both asserted in the same cycle → push accepted, overflow 0, occupancy stays 4.
- Reset mid-frame: rst after 5 pushes → next cycle out_valid 0, busy 0, no frame_done. A new start discards 3 samples again and the first output has sol=1.
